next_pc_unit: RTL

- Parametrised, registered successor to the combinational next-PC/branch-jump selector in the fetch stage.
- Owns the architectural PC register and computes PC+INC, PC-relative branch and jump targets, and register-indirect targets.
- Adds stall, halt and a circular return-address stack (RAS) for call/return target supply.
- Sits between decode/execute control and instruction-memory address.

---
 rtl/next_pc_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/next_pc_unit.sv
// next_pc_unit: registered fetch-stage PC with sequential, branch, jump,
// register-indirect and return-address-stack target selection, plus stall
// and sticky halt control.
module next_pc_unit #(
   parameter int unsigned     W         = 16,
   parameter int unsigned     DISPW     = 11,
   parameter int unsigned     INC       = 2,
   parameter int unsigned     RAS_DEPTH = 4,
   parameter logic [W-1:0]    RESET_PC  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             halt,
   input  logic             taken,
   input  logic             jump,
   input  logic             jump_type,
   input  logic             link,
   input  logic             ret,
   input  logic [DISPW-1:0] disp,
   input  logic [W-1:0]     sign_ext,
   input  logic [W-1:0]     reg_target,
   output logic [W-1:0]     pc,
   output logic [W-1:0]     pc_inc,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_mismatch,
   output logic             halted
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [W-1:0]        pc_q, pc_d;
   logic                halted_q, halted_d;
   logic                mism_q, mism_d;
   logic [PW-1:0]       top_q, top_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [W-1:0]        ras_q [RAS_DEPTH];

   logic [W-1:0]        inc_w;
   logic signed [W-1:0] disp_sx;
   logic [W-1:0]        rel_tgt;
   logic [W-1:0]        br_tgt;
   logic [W-1:0]        ras_top;
   logic [W-1:0]        tgt;
   logic                empty_w, full_w;
   logic                upd, do_pop, do_push;
   logic                ras_we;
   logic [PW-1:0]       ras_waddr;

   assign inc_w   = pc_q + W'(INC);
   assign disp_sx = {{(W-DISPW){disp[DISPW-1]}}, disp};
   assign rel_tgt = inc_w + disp_sx;
   assign br_tgt  = inc_w + sign_ext;
   assign ras_top = ras_q[top_q];
   assign empty_w = (cnt_q == '0);
   assign full_w  = (cnt_q == CW'(RAS_DEPTH));

   // A halt request freezes the PC on the same edge, so it is not an updating cycle.
   assign upd     = !stall && !halted_q && !halt;
   assign do_pop  = upd && jump && !jump_type && ret && !empty_w;
   assign do_push = upd && jump && link;

   // Simultaneous push/pop replaces the top entry in place; a lone push goes one slot above.
   assign ras_we    = do_push;
   assign ras_waddr = do_pop ? top_q : top_q + PW'(1);

   // Target priority: relative jump, RAS return, indirect jump, taken branch, sequential.
   always_comb begin
      tgt = inc_w;
      if (jump) begin
         if (jump_type)   tgt = rel_tgt;
         else if (do_pop) tgt = ras_top;
         else             tgt = reg_target;
      end else if (taken) begin
         tgt = br_tgt;
      end
   end

   // Next-state for PC, halt flag, mismatch pulse and RAS bookkeeping.
   always_comb begin
      pc_d     = pc_q;
      halted_d = halted_q;
      top_d    = top_q;
      cnt_d    = cnt_q;
      mism_d   = do_pop && (ras_top != reg_target);
      if (upd) pc_d = tgt;
      if (!stall && !halted_q && halt) halted_d = 1'b1;
      if (do_push && !do_pop) begin
         top_d = top_q + PW'(1);
         if (!full_w) cnt_d = cnt_q + CW'(1);
      end else if (do_pop && !do_push) begin
         top_d = top_q - PW'(1);
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
         mism_q   <= 1'b0;
         top_q    <= '0;
         cnt_q    <= '0;
      end else begin
         pc_q     <= pc_d;
         halted_q <= halted_d;
         mism_q   <= mism_d;
         top_q    <= top_d;
         cnt_q    <= cnt_d;
      end
   end

   // Return-address storage; contents are meaningless until pushed, so no reset.
   always_ff @(posedge clk) begin
      if (ras_we) ras_q[ras_waddr] <= inc_w;
   end

   assign pc           = pc_q;
   assign pc_inc       = inc_w;
   assign ras_empty    = empty_w;
   assign ras_full     = full_w;
   assign ras_mismatch = mism_q;
   assign halted       = halted_q;

endmodule
